// File: rtl/float_to_fixed_arbiter_pkg.sv
// Shared definitions for the float-to-fixed converter arbiter.
package float_to_fixed_arbiter_pkg;

   localparam int W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Pointer/index width: enough bits to name every requester, never less than one.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/float_to_fixed_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick
   import float_to_fixed_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = ptr_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_req
);

   logic [PTR_W:0] cand;

   // Scan offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      grant_idx = '0;
      any_req   = 1'b0;
      cand      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(N_REQ)) begin
            cand = cand - (PTR_W+1)'(N_REQ);
         end
         if (req[cand[PTR_W-1:0]]) begin
            grant_idx = cand[PTR_W-1:0];
            any_req   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/float_to_fixed_arbiter.sv
// Round-robin scheduler sharing one float-to-fixed converter between N_REQ requesters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; latches winner index and operand
// ST_ISSUE   | BEGIN_CONV pulse to the converter
// ST_WAIT    | counting cycles until ACK_CONV or the timeout limit
// ST_RELEASE | RST_CONV pulse, DONE/ERR visible, pointer advances
module float_to_fixed_arbiter
   import float_to_fixed_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = 63
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   REQ,
   input  logic [N_REQ*W-1:0] DATA_IN,
   output logic [N_REQ-1:0]   DONE,
   output logic [N_REQ-1:0]   ERR,
   output logic [W-1:0]       RESULT,
   output logic               BUSY,
   output logic               BEGIN_CONV,
   output logic [W-1:0]       DATA_CONV,
   output logic               RST_CONV,
   input  logic               ACK_CONV,
   input  logic [W-1:0]       FIXED_IN
);

   localparam int PTR_W = ptr_width(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] idx;
   logic [PTR_W-1:0] grant_idx;
   logic             any_req;
   logic [CNT_W-1:0] cnt;
   logic             cnt_at_limit;
   logic             take_ack;
   logic             take_to;
   logic [W-1:0]     din_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign din_arr[i] = DATA_IN[i*W +: W];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req       (REQ),
      .ptr       (ptr),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign cnt_at_limit = (cnt == CNT_W'(TIMEOUT));

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus state-decoded converter controls; acknowledge beats timeout on a tie.
   always_comb begin
      state_nxt  = state;
      BUSY       = 1'b1;
      BEGIN_CONV = 1'b0;
      RST_CONV   = 1'b0;
      take_ack   = 1'b0;
      take_to    = 1'b0;
      case (state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (any_req) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            BEGIN_CONV = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            if (ACK_CONV) begin
               take_ack  = 1'b1;
               state_nxt = ST_RELEASE;
            end else if (cnt_at_limit) begin
               take_to   = 1'b1;
               state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            RST_CONV  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Grant latch, timeout counter, result capture, completion pulses and pointer advance.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr       <= '0;
         idx       <= '0;
         cnt       <= '0;
         DATA_CONV <= '0;
         RESULT    <= '0;
         DONE      <= '0;
         ERR       <= '0;
      end else begin
         DONE <= '0;
         ERR  <= '0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  idx       <= grant_idx;
                  DATA_CONV <= din_arr[grant_idx];
                  cnt       <= '0;
               end
            end
            ST_WAIT: begin
               if (!cnt_at_limit) begin
                  cnt <= cnt + 1'b1;
               end
               if (take_ack) begin
                  RESULT    <= FIXED_IN;
                  DONE[idx] <= 1'b1;
               end else if (take_to) begin
                  ERR[idx] <= 1'b1;
               end
            end
            ST_RELEASE: begin
               if (idx == PTR_W'(N_REQ - 1)) begin
                  ptr <= '0;
               end else begin
                  ptr <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_fixed_arbiter.sv
// Self-checking bench: behavioural converter model plus a round-robin reference model.
module tb_float_to_fixed_arbiter;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int TMO = 63;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [N-1:0]     REQ = '0;
   logic [N*W-1:0]   DATA_IN = '0;
   logic [N-1:0]     DONE;
   logic [N-1:0]     ERR;
   logic [W-1:0]     RESULT;
   logic             BUSY;
   logic             BEGIN_CONV;
   logic [W-1:0]     DATA_CONV;
   logic             RST_CONV;
   logic             ACK_CONV;
   logic [W-1:0]     FIXED_IN;

   float_to_fixed_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ        (REQ),
      .DATA_IN    (DATA_IN),
      .DONE       (DONE),
      .ERR        (ERR),
      .RESULT     (RESULT),
      .BUSY       (BUSY),
      .BEGIN_CONV (BEGIN_CONV),
      .DATA_CONV  (DATA_CONV),
      .RST_CONV   (RST_CONV),
      .ACK_CONV   (ACK_CONV),
      .FIXED_IN   (FIXED_IN)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stand-in converter transfer function; any fixed mapping suffices.
   function automatic logic [W-1:0] conv_fn(input logic [W-1:0] x);
      return {x[15:0], x[31:16]} ^ 32'h1234_5678;
   endfunction

   // Converter model: acknowledges conv_lat cycles after the start pulse (0 = never).
   int           conv_lat = 4;
   int           c_cnt;
   logic         c_pend;
   logic         c_ack;
   logic [W-1:0] c_op;
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         c_ack  <= 1'b0;
         c_pend <= 1'b0;
         c_cnt  <= 0;
         c_op   <= '0;
      end else if (RST_CONV) begin
         c_ack  <= 1'b0;
         c_pend <= 1'b0;
      end else if (BEGIN_CONV) begin
         c_pend <= (conv_lat != 0);
         c_cnt  <= conv_lat;
         c_op   <= DATA_CONV;
      end else if (c_pend) begin
         if (c_cnt == 1) begin
            c_ack  <= 1'b1;
            c_pend <= 1'b0;
         end else begin
            c_cnt <= c_cnt - 1;
         end
      end
   end
   assign ACK_CONV = c_ack;
   assign FIXED_IN = c_ack ? conv_fn(c_op) : 32'hDEAD_BEEF;

   // Reference model state.
   logic [N-1:0] req_v = '0;
   logic [W-1:0] data_v [N];
   int           m_ptr = 0;
   logic [W-1:0] m_result = '0;

   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      REQ = req_v;
      for (int i = 0; i < N; i++) DATA_IN[i*W +: W] = data_v[i];
   endtask

   // Called in an IDLE cycle; follows one full operation to the next IDLE cycle.
   task automatic run_op(input int lat_i, input bit withdraw, output int served);
      int           exp_i;
      int           c;
      int           exp_c;
      logic [W-1:0] exp_op;
      logic [N-1:0] pulse;
      exp_i  = model_pick(req_v, m_ptr);
      served = exp_i;
      exp_op = data_v[exp_i];
      conv_lat = lat_i;
      drive();
      @(posedge CLK); #1;
      chk("begin_conv", 64'(BEGIN_CONV), 64'd1);
      chk("busy_issue", 64'(BUSY), 64'd1);
      chk("data_conv", 64'(DATA_CONV), 64'(exp_op));
      if (withdraw) begin
         req_v[exp_i]  = 1'b0;
         data_v[exp_i] = ~exp_op;
         drive();
      end
      c = 1;
      pulse = '0;
      while (pulse == '0 && c < 200) begin
         @(posedge CLK); #1;
         c++;
         pulse = DONE | ERR;
      end
      exp_c = (lat_i == 0) ? TMO + 3 : lat_i + 3;
      chk("op_cycle", 64'(c), 64'(exp_c));
      chk("onehot", 64'($countones(pulse)), 64'd1);
      if (lat_i == 0) begin
         chk("err_vec", 64'(ERR), 64'(1 << exp_i));
         chk("done_vec", 64'(DONE), 64'd0);
      end else begin
         m_result = conv_fn(exp_op);
         chk("done_vec", 64'(DONE), 64'(1 << exp_i));
         chk("err_vec", 64'(ERR), 64'd0);
      end
      chk("result", 64'(RESULT), 64'(m_result));
      chk("rst_conv", 64'(RST_CONV), 64'd1);
      @(posedge CLK); #1;
      chk("busy_idle", 64'(BUSY), 64'd0);
      chk("rst_conv_off", 64'(RST_CONV), 64'd0);
      chk("pulse_off", 64'(DONE | ERR), 64'd0);
      m_ptr = (exp_i + 1) % N;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"}, 64'(DONE), 64'd0);
      chk({tag, "_err"}, 64'(ERR), 64'd0);
      chk({tag, "_result"}, 64'(RESULT), 64'd0);
      chk({tag, "_busy"}, 64'(BUSY), 64'd0);
      chk({tag, "_begin"}, 64'(BEGIN_CONV), 64'd0);
      chk({tag, "_dconv"}, 64'(DATA_CONV), 64'd0);
      chk({tag, "_rstconv"}, 64'(RST_CONV), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      m_ptr    = 0;
      m_result = '0;
   endtask

   initial begin
      int s;
      int lat;
      for (int i = 0; i < N; i++) data_v[i] = '0;
      drive();
      repeat (3) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      RST = 1'b0;

      // Single request, converter latency 4: DONE in cycle 7.
      data_v[0] = 32'h3F80_0000;
      req_v = 4'b0001;
      run_op(4, 1'b0, s);
      req_v = '0;

      // Contention from ptr 0: order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < N; i++) data_v[i] = $urandom;
      req_v = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         run_op(int'($urandom_range(1, 6)), 1'b0, s);
         chk("rr_order", 64'(s), 64'(n % N));
         data_v[s] = $urandom;
      end
      req_v = '0;

      // Fairness across the wrap: move ptr to 3, then 1001 serves 3 then 0.
      req_v = 4'b0100;
      run_op(2, 1'b0, s);
      req_v = 4'b1001;
      run_op(3, 1'b0, s);
      chk("wrap_first", 64'(s), 64'd3);
      run_op(3, 1'b0, s);
      chk("wrap_second", 64'(s), 64'd0);
      req_v = '0;

      // Timeout with the acknowledge stuck low.
      data_v[1] = $urandom;
      req_v = 4'b0010;
      run_op(0, 1'b0, s);
      req_v = '0;

      // Acknowledge arriving on the same cycle the counter hits the limit.
      data_v[2] = $urandom;
      req_v = 4'b0100;
      run_op(TMO, 1'b0, s);
      req_v = '0;

      // Withdrawal and operand change after the grant.
      data_v[2] = $urandom;
      req_v = 4'b0100;
      run_op(5, 1'b1, s);
      chk("withdraw_idx", 64'(s), 64'd2);
      req_v = '0;

      // Asynchronous reset while waiting on the converter.
      data_v[0] = $urandom;
      req_v = 4'b0001;
      conv_lat = 10;
      drive();
      repeat (3) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      chk_all_zero("async_rst");
      req_v = '0;
      drive();
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK); #1;
         chk("rst_no_pulse", 64'(DONE | ERR), 64'd0);
      end
      RST = 1'b0;
      m_ptr    = 0;
      m_result = '0;
      data_v[1] = $urandom;
      data_v[3] = $urandom;
      req_v = 4'b1010;
      run_op(3, 1'b0, s);
      chk("post_rst_idx", 64'(s), 64'd1);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] && $urandom_range(0, 1) == 1) begin
               req_v[i]  = 1'b1;
               data_v[i] = $urandom;
            end
         end
         if (req_v == '0) begin
            s = int'($urandom_range(0, N - 1));
            req_v[s]  = 1'b1;
            data_v[s] = $urandom;
         end
         lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
         run_op(lat, 1'b0, s);
         if ($urandom_range(0, 1) == 0) req_v[s] = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
